add_rs_dispatch: RTL

Reservation station for the add/sub functional unit: holds up to three issued add/sub ops and captures missing operands from the common data bus (CDB). It dispatches the oldest ready op, one at a time, to the add execution stage with a one-cycle `ex_b` strobe. Sits between issue/decode and the add execution unit; an entry is released only when that unit reports completion.

---
 rtl/tomasulo_pkg.sv | 31 +++
 rtl/add_rs_select.sv | 24 ++
 rtl/add_rs_dispatch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared widths and reservation-station entry types for the add/sub issue path.
package tomasulo_pkg;
  localparam int NUM_ENT = 3;
  localparam int DATA_W  = 8;
  localparam int TAG_W   = 3;
  localparam int FUNC_W  = 4;
  localparam int RD_W    = 4;
  localparam int RANK_W  = 2;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    RS_FREE  = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2,
    RS_EXEC  = 2'd3
  } rs_state_t;

  typedef struct packed {
    rs_state_t           state;
    logic [FUNC_W-1:0]   func;
    logic [RD_W-1:0]     rd;
    logic [TAG_W-1:0]    rob;
    logic                src1_rdy;
    logic [DATA_W-1:0]   src1_val;
    logic [TAG_W-1:0]    src1_tag;
    logic                src2_rdy;
    logic [DATA_W-1:0]   src2_val;
    logic [TAG_W-1:0]    src2_tag;
    logic [RANK_W-1:0]   rank;
  } rs_entry_t;
endpackage

// File: rtl/add_rs_select.sv
// Combinational oldest-ready picker: lowest age rank among ready entries wins.
module add_rs_select
  import tomasulo_pkg::*;
(
  input  logic [NUM_ENT-1:0]        ready_i,
  input  logic [NUM_ENT*RANK_W-1:0] rank_i,
  output logic                      sel_valid_o,
  output logic [IDX_W-1:0]          sel_idx_o
);
  logic [RANK_W-1:0] best_rank;

  always_comb begin
    sel_valid_o = 1'b0;
    sel_idx_o   = '0;
    best_rank   = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (ready_i[i] && (!sel_valid_o || rank_i[i*RANK_W +: RANK_W] < best_rank)) begin
        sel_valid_o = 1'b1;
        sel_idx_o   = IDX_W'(i);
        best_rank   = rank_i[i*RANK_W +: RANK_W];
      end
    end
  end
endmodule

// File: rtl/add_rs_dispatch.sv
// Three-entry add/sub reservation station: issue, CDB wakeup, oldest-ready dispatch.
// Handshake: an issue is accepted on a cycle where iss_valid && iss_ready; ex_b is a one-cycle strobe.
module add_rs_dispatch
  import tomasulo_pkg::*;
(
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic [FUNC_W-1:0]    iss_func,
  input  logic [RD_W-1:0]      iss_rd,
  input  logic [TAG_W-1:0]     iss_rob,
  input  logic                 iss_src1_rdy,
  input  logic                 iss_src2_rdy,
  input  logic [DATA_W-1:0]    iss_src1_val,
  input  logic [DATA_W-1:0]    iss_src2_val,
  input  logic [TAG_W-1:0]     iss_src1_tag,
  input  logic [TAG_W-1:0]     iss_src2_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [DATA_W-1:0]    cdb_data,
  output logic                 ex_b,
  output logic [IDX_W-1:0]     ex_rs_index,
  output logic [DATA_W-1:0]    ex_rs1_data,
  output logic [DATA_W-1:0]    ex_rs2_data,
  output logic [FUNC_W-1:0]    ex_func,
  output logic [RD_W-1:0]      ex_rd,
  output logic [TAG_W-1:0]     ex_rob_ind,
  input  logic                 ex_done,
  input  logic [IDX_W-1:0]     ex_done_idx,
  output logic [1:0]           occupancy,
  output logic [2*NUM_ENT-1:0] dbg_state
);
  rs_entry_t         ent_q [NUM_ENT];
  logic              inflight_q;
  logic              ex_b_q;
  logic [IDX_W-1:0]  ex_idx_q;
  logic [DATA_W-1:0] ex_rs1_q, ex_rs2_q;
  logic [FUNC_W-1:0] ex_func_q;
  logic [RD_W-1:0]   ex_rd_q;
  logic [TAG_W-1:0]  ex_rob_q;

  logic [NUM_ENT-1:0]        free_vec, ready_vec, done_hit, cap1, cap2;
  logic [NUM_ENT*RANK_W-1:0] rank_vec;
  logic [1:0]                occ, occ_after_free;
  logic [IDX_W-1:0]          iss_idx, sel_idx;
  logic [RANK_W-1:0]         done_rank;
  logic                      done_any, iss_fire, disp_fire, sel_valid;
  logic                      iss_cap1, iss_cap2;
  logic [FUNC_W-1:0]         sel_func;
  logic [RD_W-1:0]           sel_rd;
  logic [TAG_W-1:0]          sel_rob;
  logic [DATA_W-1:0]         sel_v1, sel_v2;

  // Descending scan so the lowest-index free entry ends up as the issue target.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    done_hit  = '0;
    cap1      = '0;
    cap2      = '0;
    rank_vec  = '0;
    dbg_state = '0;
    occ       = '0;
    iss_idx   = '0;
    done_rank = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      free_vec[i]  = (ent_q[i].state == RS_FREE);
      ready_vec[i] = (ent_q[i].state == RS_READY);
      done_hit[i]  = ex_done && inflight_q && (ex_done_idx == IDX_W'(i)) &&
                     (ent_q[i].state == RS_EXEC);
      cap1[i]      = cdb_valid && !ent_q[i].src1_rdy && (ent_q[i].src1_tag == cdb_tag);
      cap2[i]      = cdb_valid && !ent_q[i].src2_rdy && (ent_q[i].src2_tag == cdb_tag);
      rank_vec[i*RANK_W +: RANK_W] = ent_q[i].rank;
      dbg_state[2*i +: 2]          = ent_q[i].state;
      if (!free_vec[i]) occ = occ + 2'd1;
      if (free_vec[i]) iss_idx = IDX_W'(i);
      if (done_hit[i]) done_rank = ent_q[i].rank;
    end
  end

  always_comb begin
    sel_func = '0;
    sel_rd   = '0;
    sel_rob  = '0;
    sel_v1   = '0;
    sel_v2   = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_func = ent_q[i].func;
        sel_rd   = ent_q[i].rd;
        sel_rob  = ent_q[i].rob;
        sel_v1   = ent_q[i].src1_val;
        sel_v2   = ent_q[i].src2_val;
      end
    end
  end

  add_rs_select u_select (
    .ready_i     (ready_vec),
    .rank_i      (rank_vec),
    .sel_valid_o (sel_valid),
    .sel_idx_o   (sel_idx)
  );

  assign done_any       = |done_hit;
  assign occ_after_free = occ - {1'b0, done_any};
  assign iss_ready      = |free_vec;
  assign iss_fire       = iss_valid && iss_ready;
  assign disp_fire      = sel_valid && !inflight_q;
  assign iss_cap1       = !iss_src1_rdy && cdb_valid && (cdb_tag == iss_src1_tag);
  assign iss_cap2       = !iss_src2_rdy && cdb_valid && (cdb_tag == iss_src2_tag);
  assign occupancy      = occ;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENT; i++) ent_q[i] <= '0;
      inflight_q <= 1'b0;
      ex_b_q     <= 1'b0;
      ex_idx_q   <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_func_q  <= '0;
      ex_rd_q    <= '0;
      ex_rob_q   <= '0;
    end else begin
      ex_b_q <= 1'b0;
      for (int i = 0; i < NUM_ENT; i++) begin
        unique case (ent_q[i].state)
          RS_FREE: begin
            if (iss_fire && iss_idx == IDX_W'(i)) begin
              ent_q[i].state    <= ((iss_src1_rdy || iss_cap1) && (iss_src2_rdy || iss_cap2)) ?
                                   RS_READY : RS_WAIT;
              ent_q[i].func     <= iss_func;
              ent_q[i].rd       <= iss_rd;
              ent_q[i].rob      <= iss_rob;
              ent_q[i].src1_rdy <= iss_src1_rdy || iss_cap1;
              ent_q[i].src1_val <= iss_src1_rdy ? iss_src1_val : cdb_data;
              ent_q[i].src1_tag <= iss_src1_tag;
              ent_q[i].src2_rdy <= iss_src2_rdy || iss_cap2;
              ent_q[i].src2_val <= iss_src2_rdy ? iss_src2_val : cdb_data;
              ent_q[i].src2_tag <= iss_src2_tag;
              ent_q[i].rank     <= occ_after_free;
            end
          end
          RS_WAIT: begin
            if (cap1[i]) begin
              ent_q[i].src1_rdy <= 1'b1;
              ent_q[i].src1_val <= cdb_data;
            end
            if (cap2[i]) begin
              ent_q[i].src2_rdy <= 1'b1;
              ent_q[i].src2_val <= cdb_data;
            end
            if ((ent_q[i].src1_rdy || cap1[i]) && (ent_q[i].src2_rdy || cap2[i]))
              ent_q[i].state <= RS_READY;
          end
          RS_READY: begin
            if (disp_fire && sel_idx == IDX_W'(i)) ent_q[i].state <= RS_EXEC;
          end
          RS_EXEC: begin
            if (done_hit[i]) begin
              ent_q[i].state <= RS_FREE;
              ent_q[i].rank  <= '0;
            end
          end
        endcase
        // Younger survivors close the age gap left by the released entry.
        if (done_any && ent_q[i].state != RS_FREE && ent_q[i].rank > done_rank)
          ent_q[i].rank <= ent_q[i].rank - 2'd1;
      end
      if (disp_fire) begin
        inflight_q <= 1'b1;
        ex_b_q     <= 1'b1;
        ex_idx_q   <= sel_idx;
        ex_rs1_q   <= sel_v1;
        ex_rs2_q   <= sel_v2;
        ex_func_q  <= sel_func;
        ex_rd_q    <= sel_rd;
        ex_rob_q   <= sel_rob;
      end else if (done_any) begin
        inflight_q <= 1'b0;
      end
    end
  end

  assign ex_b        = ex_b_q;
  assign ex_rs_index = ex_idx_q;
  assign ex_rs1_data = ex_rs1_q;
  assign ex_rs2_data = ex_rs2_q;
  assign ex_func     = ex_func_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rob_ind  = ex_rob_q;
endmodule
